// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and helpers for the bit-serial adder sequencer
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// rtl/serial_add_ctrl_fa_bit.sv - combinational 1-bit full adder cell
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add sequencer, one full-adder cell, LSB first
// Optional subtract mode (op_sub port) enabled by macro SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             op_sub,
`endif
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cell_s;
  logic             cell_c;
  logic             sub_sel;
  logic [WIDTH-1:0] sum_next;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = op_sub;
`else
  assign sub_sel = 1'b0;
`endif

  fa_bit u_cell (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (cell_s),
    .cout(cell_c)
  );

  assign sum_next = {cell_s, sum_sh[WIDTH-1:1]};

  // sum/cout are only written on the final RUN edge so they stay stable outside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      sum         <= '0;
      cout        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh        <= a;
            b_sh        <= sub_sel ? ~b : b;
            carry       <= sub_sel;
            cnt         <= '0;
            state       <= RUN;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          sum_sh <= sum_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= cell_c;
          // counter holds on the last bit instead of wrapping
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            sum       <= sum_next;
            cout      <= cell_c;
            res_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            state       <= IDLE;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          busy        <= 1'b0;
          res_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule
